// File: rtl/cart_cmd_decoder.sv
// Bluetooth cart command decoder: UART bytes in, registered motion
// command and speed out, with byte timeout and link-loss watchdog.
module cart_cmd_decoder #(
  parameter int BYTE_TO_CYC = 5_000_000,
  parameter int WDOG_CYC    = 50_000_000,
  parameter int CNT_W       = 26
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] rx_data,
  input  logic       rx_ready,
  output logic [2:0] cmd_code,
  output logic [3:0] speed,
  output logic       moving,
  output logic       cmd_valid,
  output logic       err,
  output logic       wdog_stop
);

  localparam logic [CNT_W-1:0] BYTE_MAX =
    CNT_W'(BYTE_TO_CYC - 1);
  localparam logic [CNT_W-1:0] WDOG_MAX =
    CNT_W'(WDOG_CYC - 1);

  localparam logic [7:0] CH_S = 8'h53;
  localparam logic [7:0] CH_F = 8'h46;
  localparam logic [7:0] CH_B = 8'h42;
  localparam logic [7:0] CH_L = 8'h4C;
  localparam logic [7:0] CH_R = 8'h52;

  typedef enum logic {
    IDLE,
    WAIT_SPD
  } state_t;

  state_t state_q, state_d;

  logic             sync1, sync2, sync3;
  logic             byte_stb;
  logic [7:0]       byte_q;
  logic             byte_vld;
  logic [2:0]       pend_q, pend_d;
  logic [2:0]       code_d;
  logic [3:0]       spd_d;
  logic             vld_d, err_d, wds_d;
  logic [CNT_W-1:0] bcnt_q, bcnt_d;
  logic [CNT_W-1:0] wd_q;
  logic [2:0]       dir_code;
  logic             is_stop, is_dir, is_dig;

  // rx_ready is from the baud clock domain
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      sync3 <= 1'b0;
    end else begin
      sync1 <= rx_ready;
      sync2 <= sync1;
      sync3 <= sync2;
    end
  end

  assign byte_stb = sync2 & ~sync3;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      byte_q   <= 8'h00;
      byte_vld <= 1'b0;
    end else begin
      byte_vld <= byte_stb;
      if (byte_stb)
        byte_q <= rx_data;
    end
  end

  always_comb begin
    dir_code = 3'd0;
    unique case (byte_q)
      CH_F:    dir_code = 3'd1;
      CH_B:    dir_code = 3'd2;
      CH_L:    dir_code = 3'd3;
      CH_R:    dir_code = 3'd4;
      default: dir_code = 3'd0;
    endcase
  end

  assign is_stop = (byte_q == CH_S);
  assign is_dir  = (dir_code != 3'd0);
  assign is_dig  = (byte_q >= 8'h30) &&
                   (byte_q <= 8'h39);

  always_comb begin
    state_d = state_q;
    pend_d  = pend_q;
    code_d  = cmd_code;
    spd_d   = speed;
    vld_d   = 1'b0;
    err_d   = 1'b0;
    wds_d   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (byte_vld) begin
          unique case (1'b1)
            is_stop: begin
              code_d = 3'd0;
              spd_d  = 4'd0;
              vld_d  = 1'b1;
            end
            is_dir: begin
              pend_d  = dir_code;
              state_d = WAIT_SPD;
            end
            default: err_d = 1'b1;
          endcase
        end
      end
      WAIT_SPD: begin
        if (byte_vld) begin
          state_d = IDLE;
          unique case (1'b1)
            is_dig: begin
              code_d = pend_q;
              spd_d  = byte_q[3:0];
              vld_d  = 1'b1;
            end
            is_stop: begin
              code_d = 3'd0;
              spd_d  = 4'd0;
              vld_d  = 1'b1;
            end
            default: err_d = 1'b1;
          endcase
        // a byte already in the synchroniser beats the timeout
        end else if (bcnt_q == BYTE_MAX && !byte_stb) begin
          err_d   = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    if (!vld_d && moving && wd_q == WDOG_MAX) begin
      code_d = 3'd0;
      spd_d  = 4'd0;
      wds_d  = 1'b1;
    end
  end

  always_comb begin
    bcnt_d = bcnt_q;
    if (state_q == IDLE && state_d == WAIT_SPD)
      bcnt_d = '0;
    else if (state_q == WAIT_SPD && bcnt_q != BYTE_MAX)
      bcnt_d = bcnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      pend_q    <= 3'd0;
      bcnt_q    <= '0;
      wd_q      <= '0;
      cmd_code  <= 3'd0;
      speed     <= 4'd0;
      moving    <= 1'b0;
      cmd_valid <= 1'b0;
      err       <= 1'b0;
      wdog_stop <= 1'b0;
    end else begin
      state_q   <= state_d;
      pend_q    <= pend_d;
      bcnt_q    <= bcnt_d;
      cmd_code  <= code_d;
      speed     <= spd_d;
      moving    <= (code_d != 3'd0);
      cmd_valid <= vld_d;
      err       <= err_d;
      wdog_stop <= wds_d;
      if (vld_d || !moving || wds_d)
        wd_q <= '0;
      else if (wd_q != WDOG_MAX)
        wd_q <= wd_q + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_cart_cmd_decoder.sv
// Directed bench for cart_cmd_decoder: byte vector table plus
// hand-written timeout, watchdog, reset and level-hold sequences.
module tb_cart_cmd_decoder;

  logic       clk;
  logic       rst;
  logic [7:0] rx_data;
  logic       rx_ready;
  logic [2:0] cmd_code;
  logic [3:0] speed;
  logic       moving;
  logic       cmd_valid;
  logic       err;
  logic       wdog_stop;

  int checks = 0;
  int errors = 0;

  cart_cmd_decoder #(
    .BYTE_TO_CYC(20),
    .WDOG_CYC(50),
    .CNT_W(26)
  ) dut (
    .clk(clk),
    .rst(rst),
    .rx_data(rx_data),
    .rx_ready(rx_ready),
    .cmd_code(cmd_code),
    .speed(speed),
    .moving(moving),
    .cmd_valid(cmd_valid),
    .err(err),
    .wdog_stop(wdog_stop)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] b;
    logic       v;
    logic       e;
    logic [2:0] code;
    logic [3:0] spd;
  } vec_t;

  vec_t vt[14];

  task automatic chk(input string name, input int act,
                     input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d",
               name, act, exp);
    end
  endtask

  // rising rx_ready; returns on the negedge after the 4th clk
  task automatic put(input logic [7:0] b);
    @(negedge clk);
    rx_data  = b;
    rx_ready = 1'b1;
    repeat (4) @(posedge clk);
    @(negedge clk);
  endtask

  task automatic rel();
    rx_ready = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic chk_out(input string tag, input int code,
                         input int spd, input int v,
                         input int e);
    chk({tag, ".code"}, int'(cmd_code), code);
    chk({tag, ".spd"}, int'(speed), spd);
    chk({tag, ".mov"}, int'(moving), int'(code != 0));
    chk({tag, ".vld"}, int'(cmd_valid), v);
    chk({tag, ".err"}, int'(err), e);
    chk({tag, ".wds"}, int'(wdog_stop), 0);
  endtask

  initial begin
    int k;
    int n;
    vt[0]  = '{8'h46, 1'b0, 1'b0, 3'd0, 4'd0};
    vt[1]  = '{8'h37, 1'b1, 1'b0, 3'd1, 4'd7};
    vt[2]  = '{8'h4C, 1'b0, 1'b0, 3'd1, 4'd7};
    vt[3]  = '{8'h78, 1'b0, 1'b1, 3'd1, 4'd7};
    vt[4]  = '{8'h42, 1'b0, 1'b0, 3'd1, 4'd7};
    vt[5]  = '{8'h53, 1'b1, 1'b0, 3'd0, 4'd0};
    vt[6]  = '{8'h33, 1'b0, 1'b1, 3'd0, 4'd0};
    vt[7]  = '{8'h52, 1'b0, 1'b0, 3'd0, 4'd0};
    vt[8]  = '{8'h39, 1'b1, 1'b0, 3'd4, 4'd9};
    vt[9]  = '{8'h51, 1'b0, 1'b1, 3'd4, 4'd9};
    vt[10] = '{8'h53, 1'b1, 1'b0, 3'd0, 4'd0};
    vt[11] = '{8'h4C, 1'b0, 1'b0, 3'd0, 4'd0};
    vt[12] = '{8'h30, 1'b1, 1'b0, 3'd3, 4'd0};
    vt[13] = '{8'h53, 1'b1, 1'b0, 3'd0, 4'd0};

    rst      = 1'b0;
    rx_data  = 8'h00;
    rx_ready = 1'b0;
    repeat (3) @(negedge clk);
    chk_out("reset", 0, 0, 0, 0);
    rst = 1'b1;
    repeat (2) @(negedge clk);

    for (int i = 0; i < 14; i++) begin
      put(vt[i].b);
      chk_out($sformatf("vec%0d", i), int'(vt[i].code),
              int'(vt[i].spd), int'(vt[i].v), int'(vt[i].e));
      rel();
    end

    // byte timeout: err 20 clk after entering WAIT_SPD
    put(8'h52);
    rx_ready = 1'b0;
    k = 0;
    for (int c = 1; c <= 40 && k == 0; c++) begin
      @(negedge clk);
      if (err) k = c;
    end
    chk("to.cycle", k, 20);
    chk("to.code", int'(cmd_code), 0);
    chk("to.vld", int'(cmd_valid), 0);
    repeat (3) @(negedge clk);
    put(8'h35);
    chk_out("to.idle", 0, 0, 0, 1);
    rel();

    // watchdog: stop 50 clk after the last cmd_valid
    put(8'h46);
    rel();
    put(8'h35);
    chk_out("wd.go", 1, 5, 1, 0);
    rx_ready = 1'b0;
    k = 0;
    for (int c = 1; c <= 80 && k == 0; c++) begin
      @(negedge clk);
      if (wdog_stop) k = c;
    end
    chk("wd.cycle", k, 50);
    chk("wd.code", int'(cmd_code), 0);
    chk("wd.spd", int'(speed), 0);
    chk("wd.mov", int'(moving), 0);
    chk("wd.vld", int'(cmd_valid), 0);
    n = 0;
    for (int c = 0; c < 70; c++) begin
      @(negedge clk);
      if (wdog_stop) n++;
    end
    chk("wd.once", n, 0);

    // async reset mid-frame
    put(8'h42);
    rel();
    put(8'h34);
    chk_out("rs.pre", 2, 4, 1, 0);
    rel();
    put(8'h46);
    rx_ready = 1'b0;
    #2 rst = 1'b0;
    #1;
    chk("rs.code", int'(cmd_code), 0);
    chk("rs.spd", int'(speed), 0);
    chk("rs.mov", int'(moving), 0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    put(8'h39);
    chk_out("rs.9", 0, 0, 0, 1);
    rel();
    put(8'h42);
    rel();
    put(8'h32);
    chk_out("rs.b2", 2, 2, 1, 0);
    rel();
    put(8'h53);
    chk_out("rs.stop", 0, 0, 1, 0);
    rel();

    // held rx_ready must not retrigger
    @(negedge clk);
    rx_data  = 8'h78;
    rx_ready = 1'b1;
    n = 0;
    for (int c = 0; c < 16; c++) begin
      @(negedge clk);
      if (err) n++;
    end
    chk("hold.err", n, 1);
    rel();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
